// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency instruction
// memory and feeds IF/ID with the fetched word or a bubble.
//
// state  | meaning
// FETCH  | request at pc outstanding this cycle, hit or miss decided now
// WAIT   | miss in flight, request and address held until imem_valid
// HOLD   | word returned during a stall, parked in ibuf, no request
// HALTED | HLT delivered, fetch stopped until a redirect or reset
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000,
  parameter logic [3:0]  HLT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data_in,
  input  logic        imem_valid,
  output logic [15:0] PC_out_to_IFID,
  output logic [15:0] imem_data_out_to_IFID,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ibuf;
  logic        redir_pend;
  logic [15:0] redir_pc;

  logic [15:0] pc_plus2;
  logic        deliver;
  logic [15:0] word;
  logic        is_hlt;

  assign pc_plus2 = pc + 16'd2;

  // A word is handed to IF/ID only when nothing (stall, redirect, pending redirect) overrides it.
  always_comb begin
    deliver = 1'b0;
    word    = imem_data_in;
    case (state)
      S_FETCH: deliver = imem_valid && !stall && !branch_taken;
      S_WAIT:  deliver = imem_valid && !stall && !branch_taken && !redir_pend;
      S_HOLD: begin
        deliver = !stall && !branch_taken;
        word    = ibuf;
      end
      default: deliver = 1'b0;
    endcase
    if (rst) deliver = 1'b0;
  end

  assign is_hlt = (word[15:12] == HLT_OP);

  assign imem_addr             = pc;
  assign PC_out_to_IFID        = pc_plus2;
  assign imem_rd_en            = !rst && ((state == S_FETCH) || (state == S_WAIT));
  assign halted                = !rst && (state == S_HALTED);
  assign fetch_valid           = deliver;
  assign imem_data_out_to_IFID = deliver ? word : NOP_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= S_FETCH;
      redir_pend <= 1'b0;
    end else if (deliver) begin
      // HLT keeps pc on itself so a later redirect is the only way out.
      if (is_hlt) begin
        state <= S_HALTED;
      end else begin
        pc    <= pc_plus2;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (branch_taken) begin
            pc <= branch_target;
          end else if (!imem_valid) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The memory cannot abandon the request, so a redirect during a miss waits for it.
          if (branch_taken && !imem_valid) begin
            redir_pend <= 1'b1;
            redir_pc   <= branch_target;
          end else if (branch_taken) begin
            pc         <= branch_target;
            redir_pend <= 1'b0;
            state      <= S_FETCH;
          end else if (imem_valid && redir_pend) begin
            pc         <= redir_pc;
            redir_pend <= 1'b0;
            state      <= S_FETCH;
          end else if (imem_valid) begin
            ibuf  <= imem_data_in;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            pc    <= branch_target;
            state <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (branch_taken) begin
            pc    <= branch_target;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues expected IF/ID deliveries,
// a monitor pops and compares them whenever fetch_valid is seen.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data_in = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] PC_out_to_IFID;
  logic [15:0] imem_data_out_to_IFID;
  logic        fetch_valid;
  logic        halted;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall                 (stall),
    .branch_taken          (branch_taken),
    .branch_target         (branch_target),
    .imem_rd_en            (imem_rd_en),
    .imem_addr             (imem_addr),
    .imem_data_in          (imem_data_in),
    .imem_valid            (imem_valid),
    .PC_out_to_IFID        (PC_out_to_IFID),
    .imem_data_out_to_IFID (imem_data_out_to_IFID),
    .fetch_valid           (fetch_valid),
    .halted                (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs just after the edge, optionally queue the delivery
  // expected in this cycle, and return at the falling edge for direct checks.
  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic st, input logic br, input logic [15:0] tgt,
                      input logic edv, input logic [15:0] ew, input logic [15:0] epc);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    imem_valid    = v;
    imem_data_in  = d;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (edv) begin
      e.w  = ew;
      e.pc = epc;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_delivery: got word %h pc_out %h, expected no delivery (t=%0t)",
                   imem_data_out_to_IFID, PC_out_to_IFID, $time);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_word", imem_data_out_to_IFID, e.w);
          chk("deliver_pc", PC_out_to_IFID, e.pc);
        end
      end
    end
  end

  initial begin : stim
    // reset
    step(1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    step(1, 1, 16'h1234, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("rst_rd_en", {15'b0, imem_rd_en}, 16'd0);
    chk("rst_halted", {15'b0, halted}, 16'd0);
    chk("rst_fetch_valid", {15'b0, fetch_valid}, 16'd0);
    chk("rst_data", imem_data_out_to_IFID, 16'h0000);

    // T1 hit stream
    step(0, 1, 16'h1111, 0, 0, 16'h0, 1, 16'h1111, 16'h0002);
    chk("t1_addr0", imem_addr, 16'h0000);
    chk("t1_rd_en", {15'b0, imem_rd_en}, 16'd1);
    step(0, 1, 16'h2222, 0, 0, 16'h0, 1, 16'h2222, 16'h0004);
    chk("t1_addr2", imem_addr, 16'h0002);

    // T2 miss at 0x0010, data 3 cycles after the request
    step(0, 0, 16'h0, 0, 1, 16'h0010, 0, 16'h0, 16'h0);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t2_addr", imem_addr, 16'h0010);
    chk("t2_nop0", imem_data_out_to_IFID, 16'h0000);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t2_wait_rd_en", {15'b0, imem_rd_en}, 16'd1);
    chk("t2_wait_addr", imem_addr, 16'h0010);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t2_fv_wait", {15'b0, fetch_valid}, 16'd0);
    step(0, 1, 16'h3333, 0, 0, 16'h0, 1, 16'h3333, 16'h0012);

    // T3 stall during miss
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t3_addr", imem_addr, 16'h0012);
    step(0, 1, 16'h4444, 1, 0, 16'h0, 0, 16'h0, 16'h0);
    step(0, 0, 16'h0, 1, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t3_hold_rd_en", {15'b0, imem_rd_en}, 16'd0);
    step(0, 0, 16'h0, 1, 0, 16'h0, 0, 16'h0, 16'h0);
    step(0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h4444, 16'h0014);
    chk("t3_release_rd_en", {15'b0, imem_rd_en}, 16'd0);

    // T4 redirect during miss
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t4_addr", imem_addr, 16'h0014);
    step(0, 0, 16'h0, 0, 1, 16'h0040, 0, 16'h0, 16'h0);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    step(0, 1, 16'h5555, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t4_drop_fv", {15'b0, fetch_valid}, 16'd0);
    step(0, 1, 16'h6666, 0, 0, 16'h0, 1, 16'h6666, 16'h0042);
    chk("t4_target_addr", imem_addr, 16'h0040);

    // T5 halt and resume
    step(0, 0, 16'h0, 0, 1, 16'h0008, 0, 16'h0, 16'h0);
    step(0, 1, 16'hF000, 0, 0, 16'h0, 1, 16'hF000, 16'h000A);
    chk("t5_hlt_addr", imem_addr, 16'h0008);
    step(0, 1, 16'h7777, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t5_halted", {15'b0, halted}, 16'd1);
    chk("t5_rd_en", {15'b0, imem_rd_en}, 16'd0);
    chk("t5_pc_held", imem_addr, 16'h0008);
    step(0, 0, 16'h0, 0, 1, 16'h0020, 0, 16'h0, 16'h0);
    step(0, 1, 16'h8888, 0, 0, 16'h0, 1, 16'h8888, 16'h0022);
    chk("t5_resume_addr", imem_addr, 16'h0020);
    chk("t5_unhalted", {15'b0, halted}, 16'd0);

    // stalled hit re-requests the same address
    step(0, 1, 16'h9999, 1, 0, 16'h0, 0, 16'h0, 16'h0);
    step(0, 1, 16'h9999, 0, 0, 16'h0, 1, 16'h9999, 16'h0024);
    chk("stall_hit_addr", imem_addr, 16'h0022);

    // T6 wrap, then reset in WAIT with a redirect pending
    step(0, 0, 16'h0, 0, 1, 16'hFFFE, 0, 16'h0, 16'h0);
    step(0, 1, 16'hAAAA, 0, 0, 16'h0, 1, 16'hAAAA, 16'h0000);
    chk("t6_addr_fffe", imem_addr, 16'hFFFE);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t6_wrap_addr", imem_addr, 16'h0000);
    step(0, 0, 16'h0, 0, 1, 16'h0030, 0, 16'h0, 16'h0);
    step(1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t6_rst_rd_en", {15'b0, imem_rd_en}, 16'd0);
    chk("t6_rst_halted", {15'b0, halted}, 16'd0);
    step(0, 1, 16'hBBBB, 0, 0, 16'h0, 1, 16'hBBBB, 16'h0002);
    chk("t6_post_rst_addr", imem_addr, 16'h0000);
    step(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0);
    chk("t6_next_addr", imem_addr, 16'h0002);

    chk("pending_expected", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
